// File: rtl/out_arbiter_if.sv
// -----------------------------------------------------------------------------
// out_arbiter_if
// Purpose : bundles the two 32-bit requester ports, their grant pulses and the
//           byte-wide output stream of out_arbiter into one interface.
// Signals : iReq0/iData0/oGnt0  requester 0 request, word and capture pulse
//           iReq1/iData1/oGnt1  requester 1 request, word and capture pulse
//           iReady              byte sink accepts oData this cycle
//           oData/oValid        current byte of the captured word and its valid
//           oFirst              current byte is word[31:24]
//           oSrc                index of the requester whose word is on oData
// Modports: master -- requesters and byte sink (drive the i* signals)
//           slave  -- the arbiter (drives the o* signals)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface out_arbiter_if;
    logic        iReq0;
    logic [31:0] iData0;
    logic        oGnt0;
    logic        iReq1;
    logic [31:0] iData1;
    logic        oGnt1;
    logic        iReady;
    logic [7:0]  oData;
    logic        oValid;
    logic        oFirst;
    logic        oSrc;

    modport master (
        output iReq0, iData0, iReq1, iData1, iReady,
        input  oGnt0, oGnt1, oData, oValid, oFirst, oSrc
    );

    modport slave (
        input  iReq0, iData0, iReq1, iData1, iReady,
        output oGnt0, oGnt1, oData, oValid, oFirst, oSrc
    );
endinterface

// File: rtl/out_arbiter.sv
// -----------------------------------------------------------------------------
// out_arbiter
// Purpose : two-requester arbiter that captures a 32-bit word from the winner
//           and streams it MSB byte first to a byte sink with valid/ready flow
//           control. A two-state FSM (IDLE, SEND) costs one IDLE cycle per word.
// Ports   : clk   system clock, rising edge
//           rst   asynchronous active-low reset
//           bus   out_arbiter_if.slave (requests, words, grants, byte stream)
// Config  : OUT_ARB_FIXED_PRIO_EN defined   -> requester 0 wins on contention
//           OUT_ARB_FIXED_PRIO_EN undefined -> round-robin on contention,
//                                              pointer = last granted requester
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module out_arbiter (
    input  logic          clk,
    input  logic          rst,
    out_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] word_q;
    logic [1:0]  cnt_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        first_q;
    logic        src_q;
    logic        gnt0_q;
    logic        gnt1_q;

    logic        any_req_s;
    logic        win_s;
    logic [31:0] win_word_s;
    logic        xfer_s;

`ifndef OUT_ARB_FIXED_PRIO_EN
    logic        ptr_q;   // last granted requester
`endif

    // Byte of a word selected by the byte counter, MSB byte at index 0.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    // Arbitration: choose the winner among the current requests.
    always_comb begin
        any_req_s = bus.iReq0 | bus.iReq1;
        win_s     = 1'b0;
`ifdef OUT_ARB_FIXED_PRIO_EN
        if (bus.iReq0) begin
            win_s = 1'b0;
        end else if (bus.iReq1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`else
        // On contention the requester that was not granted last wins.
        if (bus.iReq0 && bus.iReq1) begin
            win_s = ~ptr_q;
        end else if (bus.iReq1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
`endif
        if (win_s) begin
            win_word_s = bus.iData1;
        end else begin
            win_word_s = bus.iData0;
        end
        xfer_s = valid_q & bus.iReady;
    end

    // FSM with registered outputs: capture on grant, then shift out four bytes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            word_q  <= 32'd0;
            cnt_q   <= 2'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            src_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
`ifndef OUT_ARB_FIXED_PRIO_EN
            ptr_q   <= 1'b1;
`endif
        end else begin
            // Grants are single-cycle pulses unless re-armed below.
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req_s) begin
                        word_q  <= win_word_s;
                        src_q   <= win_s;
                        cnt_q   <= 2'd0;
                        data_q  <= byte_sel(win_word_s, 2'd0);
                        valid_q <= 1'b1;
                        first_q <= 1'b1;
                        gnt0_q  <= ~win_s;
                        gnt1_q  <= win_s;
`ifndef OUT_ARB_FIXED_PRIO_EN
                        ptr_q   <= win_s;
`endif
                        state_q <= ST_SEND;
                    end else begin
                        valid_q <= 1'b0;
                        first_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    // Without a transfer everything simply holds.
                    if (xfer_s) begin
                        if (cnt_q == 2'd3) begin
                            cnt_q   <= 2'd0;
                            data_q  <= 8'd0;
                            valid_q <= 1'b0;
                            first_q <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q   <= cnt_q + 2'd1;
                            data_q  <= byte_sel(word_q, cnt_q + 2'd1);
                            first_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    cnt_q   <= 2'd0;
                    valid_q <= 1'b0;
                    first_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.oData  = data_q;
    assign bus.oValid = valid_q;
    assign bus.oFirst = first_q;
    assign bus.oSrc   = src_q;
    assign bus.oGnt0  = gnt0_q;
    assign bus.oGnt1  = gnt1_q;

endmodule

// File: tb/tb_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_out_arbiter
// Purpose : self-checking bench for out_arbiter. Expected grants and bytes are
//           queued when a word is offered and compared as the DUT emits them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_out_arbiter;

    logic clk;
    logic rst;

    out_arbiter_if bus ();

    out_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic       gq[$];   // expected grant index
    logic [9:0] bq[$];   // expected {src, first, data}

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Queue the grant and the four MSB-first bytes a word should produce.
    task automatic push_word(input logic src, input logic [31:0] w);
        gq.push_back(src);
        for (int i = 0; i < 4; i++) begin
            bq.push_back({src, (i == 0) ? 1'b1 : 1'b0, w[31 - 8*i -: 8]});
        end
    endtask

    // Monitor: compare grants and transferred bytes against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.oGnt0 && bus.oGnt1) begin
                chk("gnt_exclusive", 32'd1, 32'd0);
            end
            if (bus.oGnt0 || bus.oGnt1) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", {31'd0, bus.oGnt1}, 32'hFFFF_FFFF);
                end else begin
                    chk("gnt_src", {31'd0, bus.oGnt1}, {31'd0, gq.pop_front()});
                end
            end
            if (bus.oValid && bus.iReady) begin
                if (bq.size() == 0) begin
                    chk("byte_unexpected", {22'd0, bus.oSrc, bus.oFirst, bus.oData}, 32'hFFFF_FFFF);
                end else begin
                    chk("byte", {22'd0, bus.oSrc, bus.oFirst, bus.oData}, {22'd0, bq.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait until both queues are empty and the stream is idle.
    task automatic drain(input string tag);
        int c = 0;
        while ((bq.size() != 0 || gq.size() != 0 || bus.oValid) && c < 200) begin
            tick();
            c++;
        end
        chk(tag, {31'd0, c < 200}, 32'd1);
    endtask

    // Hold the given requests until n grants are seen, then release and drain.
    task automatic run_words(input logic r0, input logic r1, input int n, input string tag);
        int g = 0;
        int c = 0;
        bus.iReq0 = r0;
        bus.iReq1 = r1;
        while (g < n && c < 200) begin
            tick();
            c++;
            if (bus.oGnt0 || bus.oGnt1) g++;
        end
        bus.iReq0 = 1'b0;
        bus.iReq1 = 1'b0;
        chk({tag, "_grants"}, g, n);
        drain({tag, "_drain"});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int c;
        int g;
        int g1;
        int g2;
        int vcnt;
        logic found;

        rst        = 1'b0;
        bus.iReq0  = 1'b0;
        bus.iReq1  = 1'b0;
        bus.iData0 = 32'd0;
        bus.iData1 = 32'd0;
        bus.iReady = 1'b1;

        // Reset state.
        #12;
        chk("rst_valid", {31'd0, bus.oValid}, 32'd0);
        chk("rst_data",  {24'd0, bus.oData},  32'd0);
        chk("rst_first", {31'd0, bus.oFirst}, 32'd0);
        chk("rst_src",   {31'd0, bus.oSrc},   32'd0);
        chk("rst_gnt",   {30'd0, bus.oGnt1, bus.oGnt0}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("idle_valid", {31'd0, bus.oValid}, 32'd0);

        // Single word from requester 0.
        bus.iData0 = 32'hA1B2C3D4;
        push_word(1'b0, 32'hA1B2C3D4);
        run_words(1'b1, 1'b0, 1, "single");

        // Backpressure while B2 is on the bus.
        push_word(1'b0, 32'hA1B2C3D4);
        bus.iReq0 = 1'b1;
        found = 1'b0;
        c = 0;
        while (!found && c < 50) begin
            tick();
            c++;
            if (bus.oGnt0) bus.iReq0 = 1'b0;
            if (bus.oValid && bus.oData == 8'hB2) found = 1'b1;
        end
        bus.iReq0 = 1'b0;
        chk("bp_reach_b2", {31'd0, found}, 32'd1);
        bus.iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_data",  {24'd0, bus.oData},  32'h0000_00B2);
            chk("bp_hold_valid", {31'd0, bus.oValid}, 32'd1);
        end
        bus.iReady = 1'b1;
        drain("bp_drain");

        // Contention from a fresh reset (pointer = requester 1).
        do_reset();
        bus.iData0 = 32'h11111111;
        bus.iData1 = 32'h22222222;
`ifdef OUT_ARB_FIXED_PRIO_EN
        push_word(1'b0, 32'h11111111);
        push_word(1'b0, 32'h11111111);
        push_word(1'b0, 32'h11111111);
`else
        push_word(1'b0, 32'h11111111);
        push_word(1'b1, 32'h22222222);
        push_word(1'b0, 32'h11111111);
`endif
        run_words(1'b1, 1'b1, 3, "contend");

        // Reset while BE of DEADBEEF is on the bus: only DE and AD transfer.
        bus.iData0 = 32'hDEADBEEF;
        gq.push_back(1'b0);
        bq.push_back({1'b0, 1'b1, 8'hDE});
        bq.push_back({1'b0, 1'b0, 8'hAD});
        bus.iReq0 = 1'b1;
        found = 1'b0;
        c = 0;
        while (!found && c < 50) begin
            tick();
            c++;
            if (bus.oGnt0) bus.iReq0 = 1'b0;
            if (bus.oValid && bus.oData == 8'hBE) found = 1'b1;
        end
        chk("mid_reach_be", {31'd0, found}, 32'd1);
        rst = 1'b0;
        bus.iReq0 = 1'b0;
        #1;
        chk("mid_valid", {31'd0, bus.oValid}, 32'd0);
        chk("mid_data",  {24'd0, bus.oData},  32'd0);
        chk("mid_first", {31'd0, bus.oFirst}, 32'd0);
        chk("mid_src",   {31'd0, bus.oSrc},   32'd0);
        chk("mid_gnt",   {30'd0, bus.oGnt1, bus.oGnt0}, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.oValid) vcnt++;
        end
        chk("mid_no_valid", vcnt, 0);
        chk("mid_bq_empty", bq.size(), 0);
        chk("mid_gq_empty", gq.size(), 0);

        // Back-to-back words from requester 1.
        bus.iData1 = 32'h5A6B7C8D;
        push_word(1'b1, 32'h5A6B7C8D);
        push_word(1'b1, 32'h5A6B7C8D);
        bus.iReq1 = 1'b1;
        g = 0;
        g1 = 0;
        g2 = 0;
        c = 0;
        while (g < 2 && c < 100) begin
            tick();
            c++;
            if (bus.oGnt1) begin
                if (g == 0) g1 = c;
                else g2 = c;
                g++;
            end
        end
        bus.iReq1 = 1'b0;
        chk("b2b_grants", g, 2);
        chk("b2b_spacing", g2 - g1, 5);
        drain("b2b_drain");
        for (int i = 0; i < 6; i++) tick();
        chk("end_idle", {31'd0, bus.oValid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/out_arbiter.md
OUT_ARBITER -- requirements
Module: out_arbiter

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-low.
REQ-003: iReq0  input  1  requester 0 has a 32-bit word pending.
REQ-004: iData0  input  32  requester 0 word; held stable while iReq0 high.
REQ-005: oGnt0  output  1  one-cycle pulse: requester 0 word captured.
REQ-006: iReq1  input  1  requester 1 has a 32-bit word pending.
REQ-007: iData1  input  32  requester 1 word; held stable while iReq1 high.
REQ-008: oGnt1  output  1  one-cycle pulse: requester 1 word captured.
REQ-009: iReady  input  1  byte sink accepts oData this cycle.
REQ-010: oData  output  8  current byte of captured word.
REQ-011: oValid  output  1  oData holds a valid byte.
REQ-012: oFirst  output  1  current byte is the MSB byte (word[31:24]).
REQ-013: oSrc  output  1  index of the requester whose word is on oData.

Function
REQ-014: The block SHALL run a two-state FSM: IDLE and SEND.
REQ-015: IDLE, no request -> stay IDLE; oValid=0.
REQ-016: IDLE, at least one request -> on that edge: capture the winner's word into a 32-bit register, set oSrc, clear the byte counter, go to SEND, and register oGnt<winner>=1 for exactly the next cycle.
REQ-017: Arbitration: only one request high -> that requester wins; both high -> winner per REQ-030.
REQ-018: SEND: oValid=1; oData = word[31:24], [23:16], [15:8], [7:0] for counter values 0, 1, 2, 3 respectively (MSB first).
REQ-019: oFirst=1 only in SEND with counter=0.
REQ-020: Byte handshake: a byte transfers on a rising edge with oValid=1 and iReady=1; counter increments by 1 (2-bit).
REQ-021: iReady=0 in SEND -> oData, oValid, counter and word hold; no timeout.
REQ-022: Transfer with counter=3 -> go to IDLE; counter wraps to 0; oValid=0 in the following cycle.
REQ-023: Each word SHALL cost one IDLE cycle; peak throughput is 4 bytes per 5 cycles.
REQ-024: Requests are not sampled in SEND. A requester still asserting iReq after its oGnt pulse is treated as a new request at the next IDLE.
REQ-025: oData, oValid, oFirst, oSrc, oGnt0 and oGnt1 SHALL be driven from registers only, with no combinational path from any input.
REQ-026: oGnt0 and oGnt1 SHALL never be high in the same cycle.

Reset
REQ-027: rst low SHALL immediately force: state=IDLE, counter=0, word=0, oData=8'd0, oValid=0, oFirst=0, oSrc=0, oGnt0=0, oGnt1=0, round-robin pointer=1 (last granted = requester 1).
REQ-028: Reset during SEND SHALL discard the in-flight word. No further bytes and no grant are produced for it.
REQ-029: After rst rises, the first edge with a request is handled per REQ-016.

Configuration
REQ-030: Macro OUT_ARB_FIXED_PRIO_EN. Defined: both requesting -> requester 0 always wins; pointer unused. Undefined (default): round-robin -> the requester not granted last wins, and the pointer updates to the winner on every grant.

Verification
REQ-031: Single word. iReq0=1, iData0=32'hA1B2C3D4, iReady=1 -> oGnt0 pulse 1 cycle. Then oValid=1 for 4 cycles with oData A1,B2,C3,D4, oFirst only on A1, oSrc=0. Then oValid=0 for 1 cycle.
REQ-032: Backpressure. As REQ-031, with iReady=0 for 3 cycles while oData=B2 -> oData stays B2, counter holds, C3 follows the first iReady=1 edge; total bytes = 4.
REQ-033: Contention, round-robin (macro undefined). iReq0=iReq1=1 held for 3 words, iData0=32'h11111111, iData1=32'h22222222 -> grant order 0,1,0; bytes 11x4, 22x4, 11x4.
REQ-034: Contention, fixed priority (macro defined). Same stimulus -> grant order 0,0,0; oGnt1 never asserted.
REQ-035: Reset mid-word. rst low while oData=32'hDEADBEEF byte BE -> all outputs 0 immediately. After release with no request, oValid stays 0 and no EF byte appears.
REQ-036: Back-to-back. iReq1 held high for 2 words, iReady=1 -> 10 cycles from the first grant to the end of the second word's IDLE, and exactly 2 oGnt1 pulses.
